// File: rtl/rgb_pwm_pkg.sv
// Shared types and default sizing for the RGB duty-cycle controller.
package rgb_pwm_pkg;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } channel_e;

    localparam int DUTY_WIDTH_DEF = 8;
    localparam int STEP_DEF       = 16;
    localparam int DUTY_INIT_DEF  = 128;

endpackage

// File: rtl/rgb_channel_reg.sv
// One colour channel: an editable shadow duty and the active duty seen by the
// PWM generator. Edits step the shadow; commit copies shadow into active.
// Build option RGB_DUTY_WRAP_EN: steps wrap modulo 2^DUTY_WIDTH instead of
// saturating at 0 / full scale.
module rgb_channel_reg
    import rgb_pwm_pkg::*;
#(
    parameter int DUTY_WIDTH = DUTY_WIDTH_DEF,
    parameter int STEP       = STEP_DEF,
    parameter int DUTY_INIT  = DUTY_INIT_DEF
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  up_en,
    input  logic                  down_en,
    input  logic                  commit,
    output logic [DUTY_WIDTH-1:0] duty
);

    localparam logic [DUTY_WIDTH-1:0] INIT_V = DUTY_WIDTH'(DUTY_INIT);

    logic [DUTY_WIDTH-1:0] shadow_r;
    logic [DUTY_WIDTH-1:0] active_r;
    logic [DUTY_WIDTH-1:0] up_val_s;
    logic [DUTY_WIDTH-1:0] down_val_s;
    logic [DUTY_WIDTH-1:0] shadow_nxt_s;

`ifdef RGB_DUTY_WRAP_EN
    localparam logic [DUTY_WIDTH-1:0] STEP_V = DUTY_WIDTH'(STEP);

    // Modulo stepping: the carry/borrow simply falls off the top.
    always_comb begin
        up_val_s   = shadow_r + STEP_V;
        down_val_s = shadow_r - STEP_V;
    end
`else
    localparam logic [DUTY_WIDTH:0] STEP_W = (DUTY_WIDTH + 1)'(STEP);
    localparam logic [DUTY_WIDTH:0] DMAX_W = {1'b0, {DUTY_WIDTH{1'b1}}};

    logic [DUTY_WIDTH:0] sum_s;
    logic [DUTY_WIDTH:0] diff_s;

    // Saturating stepping in one extra bit so the carry and borrow are visible.
    always_comb begin
        sum_s  = {1'b0, shadow_r} + STEP_W;
        diff_s = {1'b0, shadow_r} - STEP_W;
        if (sum_s > DMAX_W) begin
            up_val_s = {DUTY_WIDTH{1'b1}};
        end else begin
            up_val_s = sum_s[DUTY_WIDTH-1:0];
        end
        if (diff_s[DUTY_WIDTH]) begin
            down_val_s = {DUTY_WIDTH{1'b0}};
        end else begin
            down_val_s = diff_s[DUTY_WIDTH-1:0];
        end
    end
`endif

    // Pick the next shadow value: up+down together is the preset gesture.
    always_comb begin
        shadow_nxt_s = shadow_r;
        if (up_en && down_en) begin
            shadow_nxt_s = INIT_V;
        end else if (up_en) begin
            shadow_nxt_s = up_val_s;
        end else if (down_en) begin
            shadow_nxt_s = down_val_s;
        end else begin
            shadow_nxt_s = shadow_r;
        end
    end

    // Shadow and active registers; active loads the pre-edit shadow on commit.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= INIT_V;
            active_r <= INIT_V;
        end else begin
            shadow_r <= shadow_nxt_s;
            if (commit) begin
                active_r <= shadow_r;
            end
        end
    end

    assign duty = active_r;

endmodule

// File: rtl/rgb_duty_ctrl.sv
// RGB duty controller: button pulses select a channel and step its shadow
// duty; all three active duties update together on a PWM period boundary.
// Build option RGB_DUTY_WRAP_EN (see rgb_channel_reg): wrapping steps.
module rgb_duty_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int DUTY_WIDTH = DUTY_WIDTH_DEF,
    parameter int STEP       = STEP_DEF,
    parameter int DUTY_INIT  = DUTY_INIT_DEF
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  btn_sel_pulse,
    input  logic                  btn_up_pulse,
    input  logic                  btn_down_pulse,
    input  logic                  period_end,
    output logic [DUTY_WIDTH-1:0] duty_r,
    output logic [DUTY_WIDTH-1:0] duty_g,
    output logic [DUTY_WIDTH-1:0] duty_b,
    output logic [1:0]            sel_ch,
    output logic                  update_pending
);

    channel_e sel_r;
    channel_e sel_nxt_s;
    logic     pending_r;
    logic     change_s;
    logic     commit_s;
    logic     up_r_s, up_g_s, up_b_s;
    logic     dn_r_s, dn_g_s, dn_b_s;

    // Select FSM next state: R -> G -> B -> R on each select pulse.
    always_comb begin
        sel_nxt_s = sel_r;
        if (btn_sel_pulse) begin
            case (sel_r)
                CH_R:    sel_nxt_s = CH_G;
                CH_G:    sel_nxt_s = CH_B;
                CH_B:    sel_nxt_s = CH_R;
                default: sel_nxt_s = CH_R;
            endcase
        end else begin
            sel_nxt_s = sel_r;
        end
    end

    // Edits are steered by the current (pre-advance) selection.
    always_comb begin
        change_s = btn_up_pulse | btn_down_pulse;
        commit_s = period_end & pending_r;
        up_r_s   = btn_up_pulse   & (sel_r == CH_R);
        up_g_s   = btn_up_pulse   & (sel_r == CH_G);
        up_b_s   = btn_up_pulse   & (sel_r == CH_B);
        dn_r_s   = btn_down_pulse & (sel_r == CH_R);
        dn_g_s   = btn_down_pulse & (sel_r == CH_G);
        dn_b_s   = btn_down_pulse & (sel_r == CH_B);
    end

    // Selection state and pending flag; an edit landing on period_end keeps
    // the flag set so that edit commits on the following boundary.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r     <= CH_R;
            pending_r <= 1'b0;
        end else begin
            sel_r     <= sel_nxt_s;
            pending_r <= change_s | (pending_r & ~period_end);
        end
    end

    assign sel_ch         = sel_r;
    assign update_pending = pending_r;

    rgb_channel_reg #(.DUTY_WIDTH(DUTY_WIDTH), .STEP(STEP), .DUTY_INIT(DUTY_INIT)) u_ch_r (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .up_en   (up_r_s),
        .down_en (dn_r_s),
        .commit  (commit_s),
        .duty    (duty_r)
    );

    rgb_channel_reg #(.DUTY_WIDTH(DUTY_WIDTH), .STEP(STEP), .DUTY_INIT(DUTY_INIT)) u_ch_g (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .up_en   (up_g_s),
        .down_en (dn_g_s),
        .commit  (commit_s),
        .duty    (duty_g)
    );

    rgb_channel_reg #(.DUTY_WIDTH(DUTY_WIDTH), .STEP(STEP), .DUTY_INIT(DUTY_INIT)) u_ch_b (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .up_en   (up_b_s),
        .down_en (dn_b_s),
        .commit  (commit_s),
        .duty    (duty_b)
    );

endmodule
